// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined two-level carry-lookahead adder/subtractor.
// One SEG-bit segment is resolved per stage (L = WIDTH/SEG stages), with a
// valid/ready handshake on both sides and a single global advance enable.
// Optional feature macro: CLA_SAT_EN (saturate oS on signed overflow).
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 16
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  input  logic             iSub,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oV
);

  localparam int unsigned L  = WIDTH / SEG;
  localparam int unsigned NG = SEG / 4;

  // Two-level lookahead over one segment: returns {carry_out, sum}.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0] g, p, cb;
    logic [NG-1:0]  gg, pg;
    logic [NG:0]    cg;
    logic           t;
    g  = a & b;
    p  = a ^ b;
    cb = '0;
    gg = '0;
    pg = '0;
    cg = '0;
    t  = 1'b0;
    for (int unsigned j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
    // Each group carry is a flat sum-of-products from cin, not chained.
    for (int unsigned j = 0; j <= NG; j++) begin
      t = cin;
      for (int unsigned i = 0; i < j; i++) t = gg[i] | (pg[i] & t);
      cg[j] = t;
    end
    for (int unsigned j = 0; j < NG; j++) begin
      for (int unsigned b4 = 0; b4 < 4; b4++) begin
        t = cg[j];
        for (int unsigned i = 0; i < b4; i++) t = g[4*j+i] | (p[4*j+i] & t);
        cb[4*j+b4] = t;
      end
    end
    return {cg[NG], p ^ cb};
  endfunction

  logic             en;
  logic [WIDTH-1:0] be_eff;
  logic             ce_eff;

  logic [WIDTH-1:0] a_in [L];
  logic [WIDTH-1:0] b_in [L];
  logic [WIDTH-1:0] s_in [L];
  logic [WIDTH-1:0] s_d  [L];
  logic [L-1:0]     c_in, c_d, v_in;

  logic [WIDTH-1:0] a_q [L];
  logic [WIDTH-1:0] b_q [L];
  logic [WIDTH-1:0] s_q [L];
  logic [L-1:0]     c_q, vld_q;
  logic             ov_q;

  logic [WIDTH-1:0] s_raw, s_fin;
  logic             a_sign, ov_d;

  // Global advance: every stage shifts when the output slot is free or drained.
  assign en     = iReady | ~oValid;
  assign oReady = en;
  assign be_eff = iSub ? ~iB : iB;
  assign ce_eff = iSub ? 1'b1 : iC;

  // Per-stage wiring: stage 0 from the ports, stage k from stage k-1 registers.
  for (genvar k = 0; k < int'(L); k++) begin : g_stage
    localparam logic [WIDTH-1:0] SMASK = WIDTH'({SEG{1'b1}}) << (k*SEG);
    logic [SEG-1:0] slice;
    if (k == 0) begin : g_first
      assign a_in[k] = iA;
      assign b_in[k] = be_eff;
      assign s_in[k] = '0;
      assign c_in[k] = ce_eff;
      assign v_in[k] = iValid;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = vld_q[k-1];
    end
    assign {c_d[k], slice} = cla_seg(a_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
    assign s_d[k] = (s_in[k] & ~SMASK) | (WIDTH'(slice) << (k*SEG));
  end

  // Final stage: signed overflow from the carried sign bits, optional clamp.
  assign s_raw  = s_d[L-1];
  assign a_sign = a_in[L-1][WIDTH-1];
  assign ov_d   = (a_sign == b_in[L-1][WIDTH-1]) & (s_raw[WIDTH-1] != a_sign);
`ifdef CLA_SAT_EN
  assign s_fin  = ov_d ? (a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                       : s_raw;
`else
  assign s_fin  = s_raw;
`endif

  // Pipeline registers: all stages advance together on en, reset clears all.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      vld_q <= '0;
      c_q   <= '0;
      ov_q  <= 1'b0;
      for (int unsigned k = 0; k < L; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      vld_q <= v_in;
      c_q   <= c_d;
      ov_q  <= ov_d;
      for (int unsigned k = 0; k < L; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= (k == L-1) ? s_fin : s_d[k];
      end
    end
  end

  assign oValid = vld_q[L-1];
  assign oS     = s_q[L-1];
  assign oC     = c_q[L-1];
  assign oV     = ov_q;

  // Operand copies held by the last stage feed nothing downstream.
  logic unused_ok;
  assign unused_ok = ^{a_q[L-1], b_q[L-1]};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=32, SEG=16, two stages).
module tb_cla_pipe_adder;

  localparam int unsigned W = 32;
  localparam int          L = 2;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         lat;
    int           t;
  } exp_t;

  logic         clk, rst_n;
  logic         in_valid, out_ready_o, out_valid, down_ready;
  logic [W-1:0] a, b, s;
  logic         cin, sub, cout, ovf;

  exp_t pend;
  exp_t sb[$];
  int   n_chk, n_bad, n_out, cyc;

`ifdef CLA_SAT_EN
  localparam logic [W-1:0] OVF_ADD_S = 32'h7FFF_FFFF;
  localparam logic [W-1:0] OVF_SUB_S = 32'h8000_0000;
`else
  localparam logic [W-1:0] OVF_ADD_S = 32'h8000_0000;
  localparam logic [W-1:0] OVF_SUB_S = 32'h7FFF_FFFF;
`endif

  cla_pipe_adder #(.WIDTH(W), .SEG(16)) dut (
    .iClk(clk), .iRstN(rst_n), .iValid(in_valid), .oReady(out_ready_o),
    .iA(a), .iB(b), .iC(cin), .iSub(sub),
    .oValid(out_valid), .iReady(down_ready), .oS(s), .oC(cout), .oV(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] es, input logic ec, input logic ev);
    exp_t e;
    e.s = es; e.c = ec; e.v = ev; e.lat = 1'b1; e.t = 0;
    return e;
  endfunction

  // Reference arithmetic: wide add of the effective operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic msub);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   r;
    be = msub ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + 33'(msub ? 1'b1 : mc);
    e.s = r[W-1:0];
    e.c = r[W];
    e.v = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
`ifdef CLA_SAT_EN
    if (e.v) e.s = ma[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.lat = 1'b0;
    e.t = 0;
    return e;
  endfunction

  // Monitor: compare the queue head whenever a result is shown, pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("oS", 64'(s), 64'(sb[0].s));
          chk("oC", 64'(cout), 64'(sb[0].c));
          chk("oV", 64'(ovf), 64'(sb[0].v));
          if (down_ready) begin
            if (sb[0].lat) chk("latency", 64'(cyc - sb[0].t), 64'(L));
            void'(sb.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && out_ready_o) begin
        exp_t e;
        e = pend;
        e.t = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dc, input logic dsub, input exp_t e);
    logic acc;
    int   n;
    a = da; b = db; cin = dc; sub = dsub; pend = e; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = out_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drive_rand(input logic lat);
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    exp_t         e;
    ra = $urandom(); rb = $urandom();
    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    e = model(ra, rb, rc, rs);
    e.lat = lat;
    drive(ra, rb, rc, rs, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base;
    n_chk = 0; n_bad = 0; n_out = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; down_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    pend = mk('0, 1'b0, 1'b0);

    #12;
    chk("rst_oValid", 64'(out_valid), 64'd0);
    chk("rst_oS", 64'(s), 64'd0);
    chk("rst_oC", 64'(cout), 64'd0);
    chk("rst_oV", 64'(ovf), 64'd0);
    chk("rst_oReady", 64'(out_ready_o), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed single operations with fixed expectations and latency.
    drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0)); drain();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0)); drain();
    drive(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0001, 1'b0, 1'b0)); drain();
    drive(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0)); drain();
    drive(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0)); drain();
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(OVF_ADD_S, 1'b0, 1'b1)); drain();
    drive(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(OVF_SUB_S, 1'b1, 1'b1)); drain();

    // Full-rate stream: every result must keep the fixed latency.
    for (int i = 0; i < 8; i++) drive_rand(1'b1);
    drain();

    // Stream with a three-cycle downstream stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) drive_rand(1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        down_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_oReady", 64'(out_ready_o), 64'd0);
          @(posedge clk);
          #1;
        end
        down_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight.
    a = 32'h7FFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0;
    pend = model(a, b, cin, sub);
    in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h1234_5678; b = 32'h1111_1111;
    pend = model(a, b, cin, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_oValid", 64'(out_valid), 64'd0);
    chk("midrst_oS", 64'(s), 64'd0);
    chk("midrst_oC", 64'(cout), 64'd0);
    chk("midrst_oV", 64'(ovf), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = n_out;
    drive(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, mk(32'h0000_0003, 1'b0, 1'b0));
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_count", 64'(n_out - base), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
